// File: rtl/sc_gamecontrol_pkg.sv
// sc_gamecontrol_pkg
// Shared definitions for the game controller and the point FSM that
// consumes its commands: controller state encoding and changeP codes.
package sc_gamecontrol_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_PLAY    = 3'd2,
        ST_HIT     = 3'd3,
        ST_GOAL    = 3'd4,
        ST_OVER    = 3'd5,
        ST_WIN     = 3'd6,
        ST_WAITREL = 3'd7
    } gc_state_t;

    // Commands to the point FSM
    localparam logic [1:0] CHG_PLAY  = 2'b00;
    localparam logic [1:0] CHG_CLEAR = 2'b01;
    localparam logic [1:0] CHG_IMAGE = 2'b10;

    // Image select
    localparam logic IMG_START = 1'b0;
    localparam logic IMG_WIN   = 1'b1;

endpackage

// File: rtl/sc_gamecontrol_sync.sv
// sc_gamecontrol_sync
// Two-flop synchronizer for the raw active-low start button, followed by a
// falling-edge detector so a held button yields a single press.
// Ports:
//   clk, rst     clock, async active-high reset (flops reset to 1 = released)
//   raw_n        raw start button, active low, asynchronous
//   level        synchronized button level (1 = released)
//   fall         one-cycle pulse on synchronized 1->0 edge
module sc_gamecontrol_sync (
    input  logic clk,
    input  logic rst,
    input  logic raw_n,
    output logic level,
    output logic fall
);

    logic s1, s2, s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= raw_n;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level = s2;
    // Decoded only from flops, so no path from raw_n reaches the FSM unsynced
    assign fall  = s3 & ~s2;

endmodule

// File: rtl/sc_gamecontrol.sv
// sc_gamecontrol
// Frogger game controller: sequences start screen, frog clear bursts, play,
// game-over and win screens, and tracks lives and level.
// Ports:
//   SC_STATEMACHINEPOINT_CLOCK_50     50 MHz clock
//   SC_STATEMACHINEPOINT_RESET_InHigh async active-high reset
//   start_InLow       raw start button, active low, async
//   collision_InHigh  frog hits hazard (sync level)
//   goal_InHigh       frog in goal row (sync level)
//   changeP_OutBus    00 play, 01 clear/restart frog, 10 show image
//   image_Out         0 start/game-over, 1 win
//   lives_Out         remaining lives
//   level_Out         current level, 0-based
//   levelUp_OutHigh   one-cycle pulse on level increment
module sc_gamecontrol
    import sc_gamecontrol_pkg::*;
#(
    parameter int LIVES_INIT = 3,
    parameter int LEVEL_MAX  = 4,
    parameter int CLEAR_HOLD = 4,
    parameter int IMAGE_HOLD = 50_000_000
) (
    input  logic       SC_STATEMACHINEPOINT_CLOCK_50,
    input  logic       SC_STATEMACHINEPOINT_RESET_InHigh,
    input  logic       start_InLow,
    input  logic       collision_InHigh,
    input  logic       goal_InHigh,
    output logic [1:0] changeP_OutBus,
    output logic       image_Out,
    output logic [1:0] lives_Out,
    output logic [2:0] level_Out,
    output logic       levelUp_OutHigh
);

    // One down-counter times both the clear burst and the image hold; it is
    // sized for the longer of the two so a long clear can never truncate.
    localparam int HOLD_MAX = (IMAGE_HOLD > CLEAR_HOLD) ? IMAGE_HOLD : CLEAR_HOLD;
    localparam int CNT_W    = $clog2(HOLD_MAX + 1);

    localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_HOLD - 1);
    localparam logic [CNT_W-1:0] IMAGE_LOAD = CNT_W'(IMAGE_HOLD - 1);
    localparam logic [1:0]       LIVES_RST  = 2'(LIVES_INIT);
    localparam logic [2:0]       LEVEL_TOP  = 3'(LEVEL_MAX - 1);

    logic clk, rst;
    assign clk = SC_STATEMACHINEPOINT_CLOCK_50;
    assign rst = SC_STATEMACHINEPOINT_RESET_InHigh;

    logic start_level, start_press;

    sc_gamecontrol_sync u_sync (
        .clk   (clk),
        .rst   (rst),
        .raw_n (start_InLow),
        .level (start_level),
        .fall  (start_press)
    );

    gc_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       chg_q;
    logic             img_q;
    logic [1:0]       lives_q;
    logic [2:0]       level_q;
    logic             lvlup_q;

    // Outputs are loaded together with the state they belong to, so every
    // output is a plain flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            chg_q   <= CHG_IMAGE;
            img_q   <= IMG_START;
            lives_q <= LIVES_RST;
            level_q <= '0;
            lvlup_q <= 1'b0;
        end else begin
            lvlup_q <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    chg_q <= CHG_IMAGE;
                    img_q <= IMG_START;
                    if (start_press) begin
                        state   <= ST_START;
                        chg_q   <= CHG_CLEAR;
                        cnt     <= CLEAR_LOAD;
                        lives_q <= LIVES_RST;
                        level_q <= '0;
                    end
                end

                ST_START, ST_HIT, ST_GOAL: begin
                    if (cnt == '0) begin
                        state <= ST_PLAY;
                        chg_q <= CHG_PLAY;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                ST_PLAY: begin
                    // Collision has priority over a simultaneous goal
                    if (collision_InHigh) begin
                        if (lives_q <= 2'd1) begin
                            state   <= ST_OVER;
                            chg_q   <= CHG_IMAGE;
                            img_q   <= IMG_START;
                            cnt     <= IMAGE_LOAD;
                            lives_q <= '0;
                        end else begin
                            state   <= ST_HIT;
                            chg_q   <= CHG_CLEAR;
                            cnt     <= CLEAR_LOAD;
                            lives_q <= lives_q - 1'b1;
                        end
                    end else if (goal_InHigh) begin
                        if (level_q >= LEVEL_TOP) begin
                            state <= ST_WIN;
                            chg_q <= CHG_IMAGE;
                            img_q <= IMG_WIN;
                            cnt   <= IMAGE_LOAD;
                        end else begin
                            state   <= ST_GOAL;
                            chg_q   <= CHG_CLEAR;
                            cnt     <= CLEAR_LOAD;
                            level_q <= level_q + 1'b1;
                            lvlup_q <= 1'b1;
                        end
                    end
                end

                ST_OVER, ST_WIN: begin
                    if (cnt == '0) state <= ST_WAITREL;
                    else           cnt   <= cnt - 1'b1;
                end

                ST_WAITREL: begin
                    // A button still held from the end screen must be let go
                    // before a new game can be requested.
                    if (start_level) begin
                        state <= ST_IDLE;
                        img_q <= IMG_START;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    assign changeP_OutBus  = chg_q;
    assign image_Out       = img_q;
    assign lives_Out       = lives_q;
    assign level_Out       = level_q;
    assign levelUp_OutHigh = lvlup_q;

endmodule
